// File: rtl/instr_issue_if.sv
// Bus between the instruction issue unit (master) and the ROM, control decoder and datapath (slave).
// With ISSUE_RETIRE_CNT_EN defined the bus also carries the 32-bit retire counter.
interface instr_issue_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [5:0]        opcode;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              cu_Jump;
    logic              cu_Branch;
    logic              cu_inSignal;
    logic              cu_hlt;
    logic              alu_zero;
    logic              in_valid;
    logic              in_ready;
    logic              instr_valid;
    logic              halted;
`ifdef ISSUE_RETIRE_CNT_EN
    logic [31:0]       retire_cnt;

    modport master (
        output imem_addr, opcode, instr, pc, in_ready, instr_valid, halted, retire_cnt,
        input  imem_data, cu_Jump, cu_Branch, cu_inSignal, cu_hlt, alu_zero, in_valid
    );
    modport slave (
        input  imem_addr, opcode, instr, pc, in_ready, instr_valid, halted, retire_cnt,
        output imem_data, cu_Jump, cu_Branch, cu_inSignal, cu_hlt, alu_zero, in_valid
    );
`else
    modport master (
        output imem_addr, opcode, instr, pc, in_ready, instr_valid, halted,
        input  imem_data, cu_Jump, cu_Branch, cu_inSignal, cu_hlt, alu_zero, in_valid
    );
    modport slave (
        input  imem_addr, opcode, instr, pc, in_ready, instr_valid, halted,
        output imem_data, cu_Jump, cu_Branch, cu_inSignal, cu_hlt, alu_zero, in_valid
    );
`endif
endinterface

// File: rtl/instr_issue_unit.sv
// Fetch/issue sequencer: FETCH -> LOAD -> EXEC (-> WAIT_IN) per instruction, HALT is absorbing.
// Optional macro ISSUE_RETIRE_CNT_EN adds a 32-bit count of committed instructions.
module instr_issue_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    instr_issue_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_WAIT_IN,
        S_HALT
    } state_t;

    localparam logic [5:0]        OP_BNE = 6'b001010;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic              r_halted;

    state_t            w_state_next;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_commit;
    logic              w_in_ready;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_br_target;
    logic              w_is_bne;
    logic              w_is_branch;
    logic              w_br_taken;

    assign w_pc_inc    = r_pc + PC_ONE;
    // Offset is sign-extended to 32 bits first so the truncation wraps modulo 2^ADDR_W.
    assign w_br_target = ADDR_W'(32'(r_pc) + 32'd1 + {{16{r_ir[15]}}, r_ir[15:0]});
    assign w_is_bne    = (r_ir[31:26] == OP_BNE);
    assign w_is_branch = bus.cu_Branch || w_is_bne;
    assign w_br_taken  = (bus.cu_Branch && bus.alu_zero) || (w_is_bne && !bus.alu_zero);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_commit     = 1'b0;
        w_in_ready   = 1'b0;
        case (r_state)
            S_FETCH: w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_EXEC;
            S_EXEC: begin
                if (bus.cu_hlt) begin
                    w_state_next = S_HALT;
                end else if (bus.cu_Jump) begin
                    w_commit     = 1'b1;
                    w_pc_next    = r_ir[ADDR_W-1:0];
                    w_state_next = S_FETCH;
                end else if (w_is_branch) begin
                    w_commit     = 1'b1;
                    w_pc_next    = w_br_taken ? w_br_target : w_pc_inc;
                    w_state_next = S_FETCH;
                end else if (bus.cu_inSignal) begin
                    w_in_ready = 1'b1;
                    if (bus.in_valid) begin
                        w_commit     = 1'b1;
                        w_pc_next    = w_pc_inc;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WAIT_IN;
                    end
                end else begin
                    w_commit     = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_FETCH;
                end
            end
            S_WAIT_IN: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_commit     = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_FETCH;
                end
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_halted <= (w_state_next == S_HALT);
            if (r_state == S_LOAD) begin
                r_ir <= bus.imem_data;
            end
        end
    end

`ifdef ISSUE_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retire_cnt <= '0;
        end else if (w_commit && (r_state != S_HALT)) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.retire_cnt = r_retire_cnt;
`endif

    // The ROM address simply follows pc; FETCH is the cycle in which it is consumed.
    assign bus.imem_addr   = r_pc;
    assign bus.opcode      = r_ir[31:26];
    assign bus.instr       = r_ir;
    assign bus.pc          = r_pc;
    assign bus.in_ready    = w_in_ready;
    assign bus.instr_valid = w_commit;
    assign bus.halted      = r_halted;
endmodule
